// File: rtl/pipelined_dual_port_memory_if.sv
// Bus interface for pipelined_dual_port_memory: instruction-fetch port, data port and the
// sticky error observation signals. The processor side uses the master modport and the
// memory uses the slave modport.
interface pipelined_dual_port_memory_if;
   // Instruction-fetch port
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic        i_err;
   // Data port
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        d_err;
   // Error capture
   logic        err_sticky;
   logic [31:0] err_addr;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size,
      input  i_rdata, i_valid, i_err, d_rdata, d_valid, d_err, err_sticky, err_addr
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size,
      output i_rdata, i_valid, i_err, d_rdata, d_valid, d_err, err_sticky, err_addr
   );
endinterface

// File: rtl/pipelined_dual_port_memory.sv
// Byte-addressed unified memory with a read-only instruction port and a read/write data port.
// Big-endian byte order, fixed READ_LATENCY response pipeline on both ports, errors for
// out-of-window, misaligned and reserved-size accesses.
// Optional feature macro: MEM_ERR_STICKY_EN enables the sticky error flag and first-error
// address capture; when undefined err_sticky/err_addr are tied to 0.
module pipelined_dual_port_memory #(
   parameter int unsigned SIZE_BYTES   = 1048576,
   parameter logic [31:0] BASE_ADDR    = 32'h80020000,
   parameter int unsigned READ_LATENCY = 1
) (
   input logic                         clk,
   input logic                         rst_n,
   pipelined_dual_port_memory_if.slave bus
);

   localparam int unsigned AW  = $clog2(SIZE_BYTES);
   localparam int          LAT = int'(READ_LATENCY);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..4");
   end
   if ((SIZE_BYTES & (SIZE_BYTES - 1)) != 0) begin : g_bad_size
      $error("SIZE_BYTES must be a power of two");
   end

   // Backing store, deliberately not reset
   logic [7:0] r_mem [SIZE_BYTES];

   // 33-bit compare so index + bytes cannot wrap; an address below the base wraps to a huge
   // index and fails here
   function automatic logic f_in_range(input logic [31:0] idx, input logic [2:0] nbytes);
      return ({1'b0, idx} + {30'b0, nbytes}) <= 33'(SIZE_BYTES);
   endfunction

   logic [31:0]   w_i_idx;
   logic [31:0]   w_d_idx;
   logic [AW-1:0] w_i_off0, w_i_off1, w_i_off2, w_i_off3;
   logic [AW-1:0] w_d_off0, w_d_off1, w_d_off2, w_d_off3;
   logic [7:0]    w_i_b0, w_i_b1, w_i_b2, w_i_b3;
   logic [7:0]    w_d_b0, w_d_b1, w_d_b2, w_d_b3;
   logic          w_i_err;
   logic          w_d_err;
   logic [2:0]    w_d_nbytes;
   logic          w_d_misalign;
   logic          w_d_bad_size;
   logic [31:0]   w_d_read;
   logic [31:0]   w_i_data_s0;
   logic [31:0]   w_d_data_s0;
   logic          w_d_wr;
   logic          w_i_err_acc;
   logic          w_d_err_acc;

   assign w_i_idx = bus.i_addr - BASE_ADDR;
   assign w_d_idx = bus.d_addr - BASE_ADDR;

   // Offsets are masked to the store width; only in-range accesses ever use the data
   assign w_i_off0 = w_i_idx[AW-1:0];
   assign w_i_off1 = w_i_off0 + AW'(1);
   assign w_i_off2 = w_i_off0 + AW'(2);
   assign w_i_off3 = w_i_off0 + AW'(3);
   assign w_d_off0 = w_d_idx[AW-1:0];
   assign w_d_off1 = w_d_off0 + AW'(1);
   assign w_d_off2 = w_d_off0 + AW'(2);
   assign w_d_off3 = w_d_off0 + AW'(3);

   assign w_i_b0 = r_mem[w_i_off0];
   assign w_i_b1 = r_mem[w_i_off1];
   assign w_i_b2 = r_mem[w_i_off2];
   assign w_i_b3 = r_mem[w_i_off3];
   assign w_d_b0 = r_mem[w_d_off0];
   assign w_d_b1 = r_mem[w_d_off1];
   assign w_d_b2 = r_mem[w_d_off2];
   assign w_d_b3 = r_mem[w_d_off3];

   // Instruction fetch is always a word access
   assign w_i_err = !f_in_range(w_i_idx, 3'd4) || (|bus.i_addr[1:0]);

   // Decode data access size into byte count and alignment/size faults
   always_comb begin
      w_d_nbytes   = 3'd4;
      w_d_misalign = 1'b0;
      w_d_bad_size = 1'b0;
      case (bus.d_size)
         2'b00: begin
            w_d_nbytes   = 3'd4;
            w_d_misalign = |bus.d_addr[1:0];
         end
         2'b01: begin
            w_d_nbytes   = 3'd2;
            w_d_misalign = bus.d_addr[0];
         end
         2'b10: begin
            w_d_nbytes = 3'd1;
         end
         default: begin
            w_d_nbytes   = 3'd1;
            w_d_bad_size = 1'b1;
         end
      endcase
   end

   assign w_d_err = !f_in_range(w_d_idx, w_d_nbytes) || w_d_misalign || w_d_bad_size;

   // Right-justified, zero-extended data read
   always_comb begin
      w_d_read = 32'h0;
      case (bus.d_size)
         2'b00:   w_d_read = {w_d_b0, w_d_b1, w_d_b2, w_d_b3};
         2'b01:   w_d_read = {16'h0, w_d_b0, w_d_b1};
         2'b10:   w_d_read = {24'h0, w_d_b0};
         default: w_d_read = 32'h0;
      endcase
   end

   // Stage-0 data is forced to 0 for idle slots, errors and writes so the outputs idle at 0
   assign w_i_data_s0 = (bus.i_req && !w_i_err) ? {w_i_b0, w_i_b1, w_i_b2, w_i_b3} : 32'h0;
   assign w_d_data_s0 = (bus.d_req && !bus.d_we && !w_d_err) ? w_d_read : 32'h0;

   assign w_d_wr      = rst_n && bus.d_req && bus.d_we && !w_d_err;
   assign w_i_err_acc = bus.i_req && w_i_err;
   assign w_d_err_acc = bus.d_req && w_d_err;

   // Commit write byte lanes; reads in the same edge see the old contents
   always_ff @(posedge clk) begin
      if (w_d_wr) begin
         case (bus.d_size)
            2'b00: begin
               r_mem[w_d_off0] <= bus.d_wdata[31:24];
               r_mem[w_d_off1] <= bus.d_wdata[23:16];
               r_mem[w_d_off2] <= bus.d_wdata[15:8];
               r_mem[w_d_off3] <= bus.d_wdata[7:0];
            end
            2'b01: begin
               r_mem[w_d_off0] <= bus.d_wdata[15:8];
               r_mem[w_d_off1] <= bus.d_wdata[7:0];
            end
            2'b10: begin
               r_mem[w_d_off0] <= bus.d_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   logic [LAT-1:0]       r_i_valid;
   logic [LAT-1:0]       r_i_err;
   logic [LAT-1:0][31:0] r_i_rdata;
   logic [LAT-1:0]       r_d_valid;
   logic [LAT-1:0]       r_d_err;
   logic [LAT-1:0][31:0] r_d_rdata;

   // Response shift pipelines; reset drops everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i_valid <= '0;
         r_i_err   <= '0;
         r_i_rdata <= '0;
         r_d_valid <= '0;
         r_d_err   <= '0;
         r_d_rdata <= '0;
      end else begin
         r_i_valid[0] <= bus.i_req;
         r_i_err[0]   <= w_i_err_acc;
         r_i_rdata[0] <= w_i_data_s0;
         r_d_valid[0] <= bus.d_req;
         r_d_err[0]   <= w_d_err_acc;
         r_d_rdata[0] <= w_d_data_s0;
         for (int s = 1; s < LAT; s++) begin
            r_i_valid[s] <= r_i_valid[s-1];
            r_i_err[s]   <= r_i_err[s-1];
            r_i_rdata[s] <= r_i_rdata[s-1];
            r_d_valid[s] <= r_d_valid[s-1];
            r_d_err[s]   <= r_d_err[s-1];
            r_d_rdata[s] <= r_d_rdata[s-1];
         end
      end
   end

   assign bus.i_valid = r_i_valid[LAT-1];
   assign bus.i_err   = r_i_err[LAT-1];
   assign bus.i_rdata = r_i_rdata[LAT-1];
   assign bus.d_valid = r_d_valid[LAT-1];
   assign bus.d_err   = r_d_err[LAT-1];
   assign bus.d_rdata = r_d_rdata[LAT-1];

`ifdef MEM_ERR_STICKY_EN
   logic        r_err_sticky;
   logic [31:0] r_err_addr;

   // Capture only the first errored request; D-port wins a same-cycle tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_sticky <= 1'b0;
         r_err_addr   <= 32'h0;
      end else if (!r_err_sticky && (w_d_err_acc || w_i_err_acc)) begin
         r_err_sticky <= 1'b1;
         r_err_addr   <= w_d_err_acc ? bus.d_addr : bus.i_addr;
      end
   end

   assign bus.err_sticky = r_err_sticky;
   assign bus.err_addr   = r_err_addr;
`else
   assign bus.err_sticky = 1'b0;
   assign bus.err_addr   = 32'h0;
`endif

endmodule

// File: tb/tb_pipelined_dual_port_memory.sv
// Scoreboard bench for pipelined_dual_port_memory: directed stimulus pushes expected
// responses (data, error, arrival cycle) into per-port queues; a negedge monitor pops and
// compares whenever a valid strobe appears. Built with READ_LATENCY = 3 so the pipeline and
// the mid-flight reset are exercised with several stages in flight.
module tb_pipelined_dual_port_memory;

   localparam int unsigned LAT  = 3;
   localparam logic [31:0] BASE = 32'h80020000;
   localparam int unsigned SIZE = 1048576;
   localparam logic [31:0] TOP  = 32'h80120000; // BASE + SIZE

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        i_q[$];
   exp_t        d_q[$];

   pipelined_dual_port_memory_if bus ();

   pipelined_dual_port_memory #(
      .SIZE_BYTES  (SIZE),
      .BASE_ADDR   (BASE),
      .READ_LATENCY(LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each valid response against the head of the queue
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.i_valid) begin
            if (i_q.size() == 0) begin
               check("i_unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = i_q.pop_front();
               check("i_rdata", bus.i_rdata, e.rdata);
               check("i_err", {31'b0, bus.i_err}, {31'b0, e.err});
               check("i_latency", cyc, e.cyc);
            end
         end else begin
            check("i_idle_zero", bus.i_rdata | {31'b0, bus.i_err}, 32'h0);
         end
         if (bus.d_valid) begin
            if (d_q.size() == 0) begin
               check("d_unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = d_q.pop_front();
               check("d_rdata", bus.d_rdata, e.rdata);
               check("d_err", {31'b0, bus.d_err}, {31'b0, e.err});
               check("d_latency", cyc, e.cyc);
            end
         end else begin
            check("d_idle_zero", bus.d_rdata | {31'b0, bus.d_err}, 32'h0);
         end
      end
   end

   task automatic i_set(input logic [31:0] addr, input logic [31:0] er, input logic ee);
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
      i_q.push_back('{rdata: er, err: ee, cyc: cyc + LAT});
   endtask

   task automatic d_set(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [31:0] er, input logic ee);
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wd;
      bus.d_size  = sz;
      d_q.push_back('{rdata: er, err: ee, cyc: cyc + LAT});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
   endtask

   task automatic d_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz);
      d_set(1'b1, addr, wd, sz, 32'h0, 1'b0);
      tick();
   endtask

   task automatic d_rd(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] er,
                       input logic ee);
      d_set(1'b0, addr, 32'h0, sz, er, ee);
      tick();
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && (i_q.size() + d_q.size()) != 0; n++) tick();
      check("drain_outstanding", 32'(i_q.size() + d_q.size()), 32'h0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, {30'b0, bus.i_valid, bus.d_valid}, 32'h0);
      check({tag, "_err"}, {30'b0, bus.i_err, bus.d_err}, 32'h0);
      check({tag, "_rdata"}, bus.i_rdata | bus.d_rdata, 32'h0);
      check({tag, "_sticky"}, {31'b0, bus.err_sticky}, 32'h0);
      check({tag, "_err_addr"}, bus.err_addr, 32'h0);
   endtask

   initial begin
      bus.i_req   = 1'b0;
      bus.i_addr  = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      bus.d_size  = 2'b00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Word write/read, byte read
      d_wr(BASE, 32'hDEADBEEF, 2'b00);
      d_rd(BASE, 2'b00, 32'hDEADBEEF, 1'b0);
      d_rd(BASE + 1, 2'b10, 32'h000000AD, 1'b0);

      // Sub-word merge
      d_wr(BASE + 2, 32'h00001234, 2'b01);
      d_wr(BASE, 32'h00000055, 2'b10);
      d_rd(BASE, 2'b00, 32'h55AD1234, 1'b0);
      d_rd(BASE + 2, 2'b01, 32'h00001234, 1'b0);
      d_rd(BASE + 3, 2'b10, 32'h00000034, 1'b0);
      drain();
      check("sticky_before_errors", {31'b0, bus.err_sticky}, 32'h0);

      // Errors: misaligned, below window, reserved size; memory must be unchanged
      d_rd(BASE + 2, 2'b00, 32'h0, 1'b1);
      d_rd(32'h8001FFFC, 2'b00, 32'h0, 1'b1);
      d_set(1'b1, BASE, 32'hFFFFFFFF, 2'b11, 32'h0, 1'b1);
      tick();
      d_set(1'b1, BASE + 1, 32'hFFFFFFFF, 2'b01, 32'h0, 1'b1);
      tick();
      d_rd(BASE, 2'b00, 32'h55AD1234, 1'b0);
      drain();
`ifdef MEM_ERR_STICKY_EN
      check("err_sticky_set", {31'b0, bus.err_sticky}, 32'h1);
      check("err_addr_first", bus.err_addr, 32'h80020002);
`else
      check("err_sticky_off", {31'b0, bus.err_sticky}, 32'h0);
      check("err_addr_off", bus.err_addr, 32'h0);
`endif

      // Top-of-window boundaries on both ports
      d_wr(TOP - 4, 32'h01020304, 2'b00);
      d_wr(TOP - 1, 32'h00000077, 2'b10);
      d_rd(TOP - 4, 2'b00, 32'h01020377, 1'b0);
      d_rd(TOP - 2, 2'b01, 32'h00000377, 1'b0);
      d_rd(TOP - 1, 2'b10, 32'h00000077, 1'b0);
      d_rd(TOP, 2'b10, 32'h0, 1'b1);
      d_rd(TOP - 2, 2'b00, 32'h0, 1'b1);
      i_set(TOP - 4, 32'h01020377, 1'b0);
      tick();
      i_set(TOP, 32'h0, 1'b1);
      tick();
      i_set(BASE + 2, 32'h0, 1'b1);
      tick();
      i_set(32'h80000000, 32'h0, 1'b1);
      tick();
      drain();

      // Back-to-back pipelined reads on both ports
      d_wr(BASE + 4, 32'hCAFEF00D, 2'b00);
      d_wr(BASE + 8, 32'h12345678, 2'b00);
      d_wr(BASE + 12, 32'h0BADC0DE, 2'b00);
      i_set(BASE, 32'h55AD1234, 1'b0);
      d_set(1'b0, BASE + 12, 32'h0, 2'b00, 32'h0BADC0DE, 1'b0);
      tick();
      i_set(BASE + 4, 32'hCAFEF00D, 1'b0);
      d_set(1'b0, BASE + 8, 32'h0, 2'b00, 32'h12345678, 1'b0);
      tick();
      i_set(BASE + 8, 32'h12345678, 1'b0);
      d_set(1'b0, BASE + 4, 32'h0, 2'b00, 32'hCAFEF00D, 1'b0);
      tick();
      i_set(BASE + 12, 32'h0BADC0DE, 1'b0);
      d_set(1'b0, BASE, 32'h0, 2'b00, 32'h55AD1234, 1'b0);
      tick();
      drain();

      // Same-cycle I-read / D-write hazard, then D-read of the new data
      d_wr(BASE + 16, 32'h00000000, 2'b00);
      i_set(BASE + 16, 32'h00000000, 1'b0);
      d_set(1'b1, BASE + 16, 32'hA5A5A5A5, 2'b00, 32'h0, 1'b0);
      tick();
      d_rd(BASE + 16, 2'b00, 32'hA5A5A5A5, 1'b0);
      drain();

      // Reset with requests in flight: they are dropped
      i_set(BASE + 4, 32'hCAFEF00D, 1'b0);
      d_set(1'b0, BASE, 32'h0, 2'b00, 32'h55AD1234, 1'b0);
      tick();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      i_q.delete();
      d_q.delete();
      // Requests during reset are ignored and must not write
      bus.i_req   = 1'b1;
      bus.i_addr  = BASE;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = BASE;
      bus.d_wdata = 32'hFFFFFFFF;
      bus.d_size  = 2'b00;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check_outputs_zero("in_reset");
      end
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      rst_n     = 1'b1;
      tick();
      check("sticky_after_reset", {31'b0, bus.err_sticky}, 32'h0);
      check("err_addr_after_reset", bus.err_addr, 32'h0);
      d_rd(BASE, 2'b00, 32'h55AD1234, 1'b0);
      i_set(BASE + 4, 32'hCAFEF00D, 1'b0);
      tick();
      drain();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound in case the stimulus ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
